dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned DEPTH_DEF   = 1024;
    localparam int unsigned LATENCY_DEF = 2;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W storage: one falling-edge write port, one asynchronous read port, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = 10
) (
    input  logic              clock_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(negedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency CPU data-memory responder (valid/ready request and response, falling-edge state).
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              to_resp;
    logic              op_write;
    logic [15:0]       op_addr;
    logic [15:0]       op_wdata;
    logic              op_misaligned;
    logic [AW-1:0]     op_idx;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_we;
    logic              unused_addr_bits;

    // With LATENCY=1 the memory access happens on the acceptance edge itself,
    // so the operation fields come straight from the request while IDLE.
    assign op_write = (state_q == IDLE) ? req_write : wr_q;
    assign op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign op_idx   = AW'(32'(op_addr[10:1]) % DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
    assign op_misaligned = op_addr[0];
`else
    assign op_misaligned = 1'b0;
`endif

    assign unused_addr_bits = ^{op_addr[15:11], op_addr[0]};

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock_i (clock),
        .we_i    (mem_we),
        .waddr_i (op_idx),
        .wdata_i (op_wdata),
        .raddr_i (op_idx),
        .rdata_o (mem_rdata)
    );

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                        to_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    to_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (to_resp) begin
            rdata_d = (op_write || op_misaligned) ? '0 : mem_rdata;
            err_d   = op_misaligned;
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        mem_we     = to_resp && op_write && !op_misaligned;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule
